floating_point_divider: RTL and testbench

- Iterative IEEE-754 single-precision divider that computes quotient = A / B.
- It is the inverse companion of the combinational floating-point multiplier and sits beside it in the arithmetic datapath.
- It uses a start/busy/done handshake and a fixed latency, so controllers can schedule it deterministically.
- It uses restoring mantissa division (one quotient bit per clock), then normalises and rounds to nearest-even.

---
 rtl/floating_point_divider.sv | 136 +++++++++++++
 tb/tb_floating_point_divider.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/floating_point_divider.sv
// floating_point_divider: iterative IEEE-754 single-precision A/B, restoring division, round-to-nearest-even, fixed 28-cycle latency
module floating_point_divider #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] quotient,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        invalid
);
  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, b_q, sval_q, quot_q;
  logic sign_q, spec_q, sinv_q, sdz_q, dz_q, inv_q;
  logic signed [9:0] e_q;
  logic [23:0] mb_q;
  logic [24:0] r_q;
  logic [25:0] q_q;
  logic [4:0] cnt_q;
  logic [7:0] ea, eb;
  logic za, zb, ia, ib, nan_any, sp, sinv, sdz, s;
  logic [31:0] sv;
  logic ge;
  logic [23:0] rs;
  logic norm, g, st, inc, cy;
  logic [22:0] frac, frac_r;
  logic signed [9:0] e1, e2;
  logic [31:0] res;
  assign busy = (state_q == UNPACK) || (state_q == DIVIDE) || (state_q == ROUND);
  assign done = (state_q == DONE);
  assign quotient = quot_q;
  assign div_by_zero = dz_q;
  assign invalid = inv_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? UNPACK : IDLE;
      UNPACK:     state_d = DIVIDE;
      DIVIDE:     state_d = (cnt_q == 5'd0) ? ROUND : DIVIDE;
      ROUND:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end
  // Operand classification; denormal operands count as zero
  always_comb begin
    ea = a_q[30:23];
    eb = b_q[30:23];
    s = a_q[31] ^ b_q[31];
    za = (ea == 8'h00);
    zb = (eb == 8'h00);
    ia = (&ea) && (a_q[22:0] == 23'h0);
    ib = (&eb) && (b_q[22:0] == 23'h0);
    nan_any = ((&ea) && (|a_q[22:0])) || ((&eb) && (|b_q[22:0]));
    sinv = nan_any || (za && zb) || (ia && ib);
    sp = nan_any || za || zb || ia || ib;
    sdz = zb && !sinv && !ia;
    sv = sinv ? CANON_NAN : (ia || zb) ? {s, 8'hFF, 23'h0} : {s, 31'h0};
  end
  // One restoring step: partial remainder always stays below 2*mb, so 25 bits suffice
  always_comb begin
    ge = r_q >= {1'b0, mb_q};
    rs = ge ? 24'(r_q - {1'b0, mb_q}) : r_q[23:0];
  end
  // q[24] is guaranteed set when q[25] is clear, so only the fraction bits are carried;
  // a carry out of the 23-bit fraction leaves it at zero, which is exactly 1.0 renormalised
  always_comb begin
    norm = q_q[25];
    frac = norm ? q_q[24:2] : q_q[23:1];
    g = norm ? q_q[1] : q_q[0];
    st = (norm & q_q[0]) | (|r_q);
    inc = g & (st | frac[0]);
    {cy, frac_r} = {1'b0, frac} + {23'h0, inc};
    e1 = norm ? e_q : e_q - 10'sd1;
    e2 = e1 + $signed({9'h0, cy});
    res = (e2 >= 10'sd255) ? {sign_q, 8'hFF, 23'h0} :
          (e2 <= 10'sd0) ? {sign_q, 31'h0} : {sign_q, e2[7:0], frac_r};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      sval_q <= '0;
      quot_q <= '0;
      sign_q <= 1'b0;
      spec_q <= 1'b0;
      sinv_q <= 1'b0;
      sdz_q <= 1'b0;
      dz_q <= 1'b0;
      inv_q <= 1'b0;
      e_q <= '0;
      mb_q <= '0;
      r_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
    end else
      case (state_q)
        IDLE, DONE:
          if (start) begin
            a_q <= A;
            b_q <= B;
            dz_q <= 1'b0;
            inv_q <= 1'b0;
          end
        UNPACK: begin
          sign_q <= s;
          e_q <= $signed({2'b00, ea} - {2'b00, eb} + 10'd127);
          r_q <= {2'b01, a_q[22:0]};
          mb_q <= {1'b1, b_q[22:0]};
          q_q <= '0;
          cnt_q <= 5'd25;
          spec_q <= sp;
          sinv_q <= sinv;
          sdz_q <= sdz;
          sval_q <= sv;
        end
        DIVIDE: begin
          r_q <= {rs, 1'b0};
          q_q <= {q_q[24:0], ge};
          cnt_q <= cnt_q - 5'd1;
        end
        ROUND: begin
          quot_q <= spec_q ? sval_q : res;
          inv_q <= sinv_q;
          dz_q <= sdz_q;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_floating_point_divider.sv
// tb_floating_point_divider: randomized and directed checks of floating_point_divider against a real-arithmetic reference
module tb_floating_point_divider;
  logic clk = 1'b0;
  logic reset, start;
  logic [31:0] A, B, quotient;
  logic busy, done, div_by_zero, invalid;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  floating_point_divider dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .quotient(quotient), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .invalid(invalid)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] to_dbl(input logic [31:0] x);
    return {1'b0, 11'(x[30:23]) + 11'd896, x[22:0], 29'h0};
  endfunction
  // Returns {invalid, div_by_zero, quotient}
  function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic s, za, zb, ia, ib, na, nb, g, st;
    real ra, rb;
    logic [63:0] d;
    logic [23:0] m;
    logic [24:0] mr;
    int fe;
    s = a[31] ^ b[31];
    za = a[30:23] == 8'h00;
    zb = b[30:23] == 8'h00;
    ia = a[30:23] == 8'hFF && a[22:0] == 23'h0;
    ib = b[30:23] == 8'hFF && b[22:0] == 23'h0;
    na = a[30:23] == 8'hFF && a[22:0] != 23'h0;
    nb = b[30:23] == 8'hFF && b[22:0] != 23'h0;
    if (na || nb || (za && zb) || (ia && ib)) return {2'b10, 32'h7FC00000};
    if (ia) return {2'b00, s, 8'hFF, 23'h0};
    if (zb) return {2'b01, s, 8'hFF, 23'h0};
    if (za || ib) return {2'b00, s, 31'h0};
    ra = $bitstoreal(to_dbl(a));
    rb = $bitstoreal(to_dbl(b));
    d = $realtobits(ra / rb);
    fe = int'(d[62:52]) - 1023 + 127;
    m = {1'b1, d[51:29]};
    g = d[28];
    st = |d[27:0];
    mr = {1'b0, m} + {24'h0, g && (st || m[0])};
    if (mr[24]) fe++;
    if (fe >= 255) return {2'b00, s, 8'hFF, 23'h0};
    if (fe <= 0) return {2'b00, s, 31'h0};
    return {2'b00, s, fe[7:0], mr[22:0]};
  endfunction
  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: r[30:0] = 31'h0;
      1: r[30:0] = {8'hFF, 23'h0};
      2: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
      3: r[30:23] = 8'h00;
      4: r[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFE : 8'h01;
      5: ;
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction
  // Launches one operation (b2b: start in the current DONE cycle), optionally pokes start
  // with junk operands at busy cycle inj, then checks latency, flags and result
  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit b2b, input int inj);
    logic [33:0] m;
    int n;
    m = ref_div(a, b);
    if (!b2b) @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_on", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      if (n == inj) begin
        A = $urandom;
        B = $urandom;
        start = 1'b1;
      end else start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check("latency", n, 32'd28);
    check("busy_at_done", 32'(busy), 32'd0);
    check("quotient", quotient, m[31:0]);
    check("div_by_zero", 32'(div_by_zero), 32'(m[32]));
    check("invalid", 32'(invalid), 32'(m[33]));
  endtask
  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", quotient, 32'h0);
    check("rst_ctrl", {28'h0, busy, done, div_by_zero, invalid}, 32'h0);
    @(negedge clk) reset = 1'b0;
    run(32'h40C00000, 32'h40000000, 1'b0, -1);
    check("six_by_two", quotient, 32'h40400000);
    run(32'h3F800000, 32'h40400000, 1'b0, -1);
    check("one_third", quotient, 32'h3EAAAAAB);
    run(32'hC1000000, 32'h40000000, 1'b1, -1);
    check("b2b_neg", quotient, 32'hC0800000);
    run(32'h3F800000, 32'h00000000, 1'b0, -1);
    check("dz_q", quotient, 32'h7F800000);
    check("dz_flag", 32'(div_by_zero), 32'd1);
    run(32'h00000000, 32'h00000000, 1'b0, -1);
    check("zz_q", quotient, 32'h7FC00000);
    check("zz_inv", 32'(invalid), 32'd1);
    run(32'h7F800000, 32'hFF800000, 1'b0, -1);
    check("infinf_q", quotient, 32'h7FC00000);
    check("infinf_inv", 32'(invalid), 32'd1);
    run(32'h7F000000, 32'h3E800000, 1'b0, -1);
    check("overflow", quotient, 32'h7F800000);
    run(32'h00800000, 32'h40000000, 1'b0, -1);
    check("underflow", quotient, 32'h00000000);
    run(32'h40C00000, 32'h40000000, 1'b0, 5);
    check("ignored_start", quotient, 32'h40400000);
    @(negedge clk);
    A = 32'h3F800000;
    B = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_quotient", quotient, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check("no_done_after_abort", seen, 32'd0);
    run(32'h40C00000, 32'h40000000, 1'b0, -1);
    check("after_abort", quotient, 32'h40400000);
    for (int i = 0; i < 200; i++)
      run(rnd_op(), rnd_op(), $urandom_range(0, 3) == 0, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 26)) : -1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
